// File: rtl/booth_dot_seq.sv
// rtl/booth_dot_seq.sv - operand sequencer and dot-product accumulator around a Booth multiplier
module booth_dot_seq #(
  parameter int ACC_W      = 40,
  parameter int HI_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_x_i,
  input  logic [15:0]      in_y_i,
  input  logic             in_last_i,
  output logic [15:0]      mul_x_o,
  output logic [15:0]      mul_y_o,
  output logic             mul_start_o,
  input  logic             mul_busy_i,
  input  logic [31:0]      mul_z_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_o,
  output logic [7:0]       out_cnt_o,
  output logic             out_ovf_o,
  output logic             out_err_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_ACCUM   = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  // Timeout counter counts WAIT_HI cycles 0..HI_TIMEOUT-1
  localparam int TW = (HI_TIMEOUT < 2) ? 1 : $clog2(HI_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(HI_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             mul_start_q, mul_start_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      mul_x_q, mul_x_d;
  logic [15:0]      mul_y_q, mul_y_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [31:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;

  assign prod_ext = ACC_W'($signed(prod_q));
  assign sum      = acc_q + prod_ext;

  // Next-state logic for the sequencer, datapath registers and registered handshakes
  always_comb begin
    state_d = state_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    last_d  = last_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          mul_x_d = in_x_i;
          mul_y_d = in_y_i;
          last_d  = in_last_i;
          // A new vector starts with a clean accumulator and clean flags
          if (first_q) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            first_d = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mul_busy_i) begin
          state_d = S_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          // Multiplier never acknowledged: contribute nothing, flag it
          err_d   = 1'b1;
          prod_d  = '0;
          state_d = S_ACCUM;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!mul_busy_i) begin
          prod_d  = mul_z_i;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = sum;
        if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1])) begin
          ovf_d = 1'b1;
        end
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (out_ready_i) begin
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    mul_start_d = (state_d == S_ISSUE);
    out_valid_d = (state_d == S_OUT);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      tmo_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      last_q      <= last_d;
      first_q     <= first_d;
      tmo_q       <= tmo_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mul_start_o = mul_start_q;
  assign mul_x_o     = mul_x_q;
  assign mul_y_o     = mul_y_q;
  assign out_valid_o = out_valid_q;
  assign out_acc_o   = acc_q;
  assign out_cnt_o   = cnt_q;
  assign out_ovf_o   = ovf_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_booth_dot_seq.sv
// tb/tb_booth_dot_seq.sv - self-checking bench for booth_dot_seq at ACC_W=40 and ACC_W=33
module tb_booth_dot_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        mul_busy;

  logic        in_ready0, mul_start0, out_valid0, out_ovf0, out_err0;
  logic [15:0] mul_x0, mul_y0;
  logic [31:0] mul_z0;
  logic [39:0] out_acc0;
  logic [7:0]  out_cnt0;

  logic        in_ready1, mul_start1, out_valid1, out_ovf1, out_err1;
  logic [15:0] mul_x1, mul_y1;
  logic [31:0] mul_z1;
  logic [32:0] out_acc1;
  logic [7:0]  out_cnt1;

  booth_dot_seq #(.ACC_W(40), .HI_TIMEOUT(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_x_i(in_x), .in_y_i(in_y), .in_last_i(in_last),
    .mul_x_o(mul_x0), .mul_y_o(mul_y0), .mul_start_o(mul_start0),
    .mul_busy_i(mul_busy), .mul_z_i(mul_z0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_acc_o(out_acc0),
    .out_cnt_o(out_cnt0), .out_ovf_o(out_ovf0), .out_err_o(out_err0));

  booth_dot_seq #(.ACC_W(33), .HI_TIMEOUT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_x_i(in_x), .in_y_i(in_y), .in_last_i(in_last),
    .mul_x_o(mul_x1), .mul_y_o(mul_y1), .mul_start_o(mul_start1),
    .mul_busy_i(mul_busy), .mul_z_i(mul_z1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_acc_o(out_acc1),
    .out_cnt_o(out_cnt1), .out_ovf_o(out_ovf1), .out_err_o(out_err1));

  // Ideal multiplier: product is combinational, busy shape is configurable
  assign mul_z0 = 32'($signed(mul_x0) * $signed(mul_y0));
  assign mul_z1 = 32'($signed(mul_x1) * $signed(mul_y1));

  int  hi_dly = 0;
  int  busy_len = 34;
  bit  stuck = 1'b0;
  bit  run;
  int  t;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0; t <= 0; mul_busy <= 1'b0;
    end else if (mul_start0) begin
      run <= 1'b1; t <= 1;
      mul_busy <= !stuck && (hi_dly == 0) && (busy_len > 0);
    end else if (run) begin
      t <= t + 1;
      mul_busy <= !stuck && (t >= hi_dly) && (t < hi_dly + busy_len);
      if (t > hi_dly + busy_len + 40) run <= 1'b0;
    end
  end

  int start_cnt = 0;
  int start_dbl = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (mul_start0) start_cnt++;
    if (mul_start0 && start_prev) start_dbl++;
    start_prev = mul_start0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrapw(input longint s, input int w);
    return (s <<< (64 - w)) >>> (64 - w);
  endfunction

  // Exact-sum reference: overflow means the wrapped sum differs from the true sum
  function automatic void ref_acc(input int w, input longint prods[$], output longint acc, output bit ovf);
    longint s;
    acc = 0; ovf = 1'b0;
    foreach (prods[i]) begin
      s = acc + prods[i];
      if (wrapw(s, w) != s) ovf = 1'b1;
      acc = wrapw(s, w);
    end
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, " in_ready"}, in_ready0, 0);
    chk({nm, " mul_start"}, mul_start0, 0);
    chk({nm, " mul_x"}, mul_x0, 0);
    chk({nm, " out_valid"}, out_valid0, 0);
    chk({nm, " out_acc"}, out_acc0, 0);
    chk({nm, " out_cnt"}, out_cnt0, 0);
    chk({nm, " out_err"}, out_err0, 0);
  endtask

  task automatic send_pair(input int x, input int y, input bit last);
    int k = 0;
    in_x = x[15:0]; in_y = y[15:0]; in_last = last; in_valid = 1'b1;
    while (!in_ready0 && k < 2000) begin @(negedge clk); k++; end
    if (!in_ready0) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input longint e40, input bit o40, input longint e33,
                             input bit o33, input int ecnt, input bit eerr);
    int k = 0;
    while (!out_valid0 && k < 2000) begin @(negedge clk); k++; end
    chk({nm, " out_valid"}, out_valid0, 1);
    chk({nm, " out_valid33"}, out_valid1, 1);
    chk({nm, " acc40"}, $signed(out_acc0), e40);
    chk({nm, " ovf40"}, out_ovf0, o40);
    chk({nm, " acc33"}, $signed(out_acc1), e33);
    chk({nm, " ovf33"}, out_ovf1, o33);
    chk({nm, " cnt"}, out_cnt0, ecnt);
    chk({nm, " err"}, out_err0, eerr);
    if (out_ready) begin
      @(negedge clk);
      chk({nm, " consumed"}, out_valid0, 0);
    end
  endtask

  typedef struct {
    int x; int y; bit last; bit stk;
    longint e40; bit o40; longint e33; bit o33; int cnt; bit err;
  } row_t;
  row_t tbl[$];

  function automatic row_t mk(input int x, input int y, input bit last, input bit stk,
                              input longint e40, input bit o40, input longint e33, input bit o33,
                              input int cnt, input bit err);
    row_t r;
    r.x = x; r.y = y; r.last = last; r.stk = stk;
    r.e40 = e40; r.o40 = o40; r.e33 = e33; r.o33 = o33; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  initial begin
    int terms;
    int s0;
    int cyc;
    longint prods[$];
    int xs[$];
    int ys[$];
    longint ea40, ea33;
    bit eo40, eo33, vstk;
    int n;
    logic [39:0] held;

    tbl.push_back(mk(3, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, -1, 1, 0, -5, 0, -5, 0, 3, 0));
    tbl.push_back(mk(-32768, -32768, 1, 0, 64'h40000000, 0, 64'h40000000, 0, 1, 0));
    tbl.push_back(mk(5, 5, 1, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(-32768, -32768, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-32768, -32768, 1, 0, 64'h80000000, 0, 64'h80000000, 0, 2, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(-32768, -32768, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-32768, -32768, 1, 0, 64'h100000000, 0, -64'sh100000000, 1, 4, 0));

    #1;
    chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready0, 1);

    // Directed table
    terms = 0; s0 = start_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      stuck = tbl[i].stk;
      if (terms == 0) s0 = start_cnt;
      send_pair(tbl[i].x, tbl[i].y, tbl[i].last);
      terms++;
      if (tbl[i].last) begin
        wait_result($sformatf("tbl%0d", i), tbl[i].e40, tbl[i].o40, tbl[i].e33, tbl[i].o33,
                    tbl[i].cnt, tbl[i].err);
        chk($sformatf("tbl%0d starts", i), start_cnt - s0, terms);
        terms = 0;
      end
    end
    stuck = 1'b0;

    // Busy never rises: ISSUE, 8 WAIT_HI cycles, ACCUM, then OUT
    stuck = 1'b1;
    send_pair(5, 5, 1);
    chk("timeout issue", mul_start0, 1);
    cyc = 0;
    while (!out_valid0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("timeout latency", cyc, 10);
    wait_result("timeout", 0, 0, 0, 0, 1, 1);
    stuck = 1'b0;

    // Stalled consumer holds OUT; in_valid is ignored meanwhile
    out_ready = 1'b0;
    send_pair(4, 4, 1);
    wait_result("stall", 16, 0, 16, 0, 1, 0);
    held = out_acc0;
    s0 = start_cnt;
    in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h0042; in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall valid", out_valid0, 1);
      chk("stall acc", out_acc0, held);
      chk("stall in_ready", in_ready0, 0);
    end
    chk("stall no start", start_cnt - s0, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send_pair(2, 3, 1);
    wait_result("after stall", 6, 0, 6, 0, 1, 0);

    // Count saturation
    hi_dly = 0; busy_len = 1;
    for (int i = 0; i < 260; i++) send_pair(1, 1, i == 259);
    wait_result("saturate", 260, 0, 260, 0, 255, 0);

    // Reset while waiting for busy to fall on the second term
    busy_len = 34;
    send_pair(9, 9, 0);
    send_pair(3, 3, 1);
    cyc = 0;
    while (!mul_busy && cyc < 50) begin @(negedge clk); cyc++; end
    chk("busy rose", mul_busy, 1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(1, 1, 1);
    wait_result("post reset", 1, 0, 1, 0, 1, 0);

    // Randomized vectors against the exact-sum reference
    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(1, 5);
      vstk = ($urandom_range(0, 7) == 0);
      hi_dly = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 40);
      xs.delete(); ys.delete(); prods.delete();
      for (int i = 0; i < n; i++) begin
        xs.push_back(($urandom_range(0, 3) == 0) ? -32768 : int'($signed(16'($urandom()))));
        ys.push_back(($urandom_range(0, 3) == 0) ? -32768 : int'($signed(16'($urandom()))));
        prods.push_back(vstk ? 64'sd0 : longint'(xs[i]) * longint'(ys[i]));
      end
      ref_acc(40, prods, ea40, eo40);
      ref_acc(33, prods, ea33, eo33);
      stuck = vstk;
      for (int i = 0; i < n; i++) send_pair(xs[i], ys[i], i == n - 1);
      wait_result($sformatf("rand%0d", v), ea40, eo40, ea33, eo33, n, vstk);
    end
    stuck = 1'b0;

    chk("start pulse width", start_dbl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
